// File: rtl/router_in_port_pkg.sv
// Shared types and routing rule for the router ingress port.
package router_in_port_pkg;

    localparam int NUM_NODES        = 6;
    localparam int NODES_PER_ROUTER = 3;
    localparam int NUM_PORTS        = 4;

    // Highest destination that names a real node; anything above is dropped.
    localparam logic [3:0] MAX_DEST = 4'(NUM_NODES - 1);

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    // One-hot output port for a destination seen from router rid:
    // local nodes map to ports 0..2, other valid nodes leave on the
    // inter-router link (top port), invalid nodes get no request.
    function automatic logic [3:0] route_port(int rid, logic [3:0] dest);
        int         lo;
        int         d;
        logic [3:0] port;
        lo   = NODES_PER_ROUTER * rid;
        d    = int'(dest);
        port = 4'b0000;
        if (d < NUM_NODES) begin
            if (d >= lo && d < lo + NODES_PER_ROUTER) begin
                port = 4'b0001 << (d - lo);
            end else begin
                port = 4'b0001 << (NUM_PORTS - 1);
            end
        end
        return port;
    endfunction

endpackage

// File: rtl/router_in_port_if.sv
// Handshake bundle between an upstream node, the ingress port and the crossbar.
interface router_in_port_if;
    import router_in_port_pkg::*;

    logic       put_in;
    logic [7:0] payload_in;
    logic       free_in;
    pkt_t       pkt_out;
    logic       pkt_valid;
    logic [3:0] req;
    logic       grant;

    modport master (
        output put_in, payload_in, grant,
        input  free_in, pkt_out, pkt_valid, req
    );

    modport slave (
        input  put_in, payload_in, grant,
        output free_in, pkt_out, pkt_valid, req
    );

endinterface

// File: rtl/router_in_port_pkt_fifo.sv
// Whole-packet FIFO with a combinational head read. A push while full is
// only honoured when a pop frees the head slot on the same edge.
module router_in_port_pkt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage is not reset; the head is only meaningful while not empty.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally; count tracks occupancy including push+pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/router_in_port.sv
// Router ingress port: reassembles the 4-byte serial stream into packets,
// queues whole packets and presents the head with a one-hot port request.
module router_in_port
    import router_in_port_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    router_in_port_if.slave  port_if,
    output logic             err_ovf,
    output logic             err_dest
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]    r_byte_cnt;
    logic [3:0]    r_src;
    logic [3:0]    r_dest;
    logic [15:0]   r_data_hi;
    logic          r_free;
    logic          r_err_ovf;
    logic          r_err_dest;

    logic          w_take;
    logic          w_ovf;
    logic          w_last;
    logic          w_dest_bad;
    logic          w_push;
    logic          w_pop;
    logic          w_push_eff;
    logic [1:0]    w_cnt_next;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_full;
    logic          w_empty;
    pkt_t          w_asm;
    pkt_t          w_head;

    // A header byte is refused while the queue is full, so byte_cnt only
    // leaves 0 once a slot is guaranteed for the packet in flight.
    assign w_take       = port_if.put_in && ((r_byte_cnt != 2'd0) || !w_full);
    assign w_ovf        = port_if.put_in && (r_byte_cnt == 2'd0) && w_full;
    assign w_last       = w_take && (r_byte_cnt == 2'd3);
    assign w_cnt_next   = w_take ? r_byte_cnt + 2'd1 : r_byte_cnt;
    assign w_asm        = '{src: r_src, dest: r_dest, data: {r_data_hi, port_if.payload_in}};
    assign w_dest_bad   = (r_dest > MAX_DEST);
    assign w_push       = w_last && !w_dest_bad;
    assign w_pop        = port_if.grant && !w_empty;
    assign w_push_eff   = w_push && (!w_full || w_pop);
    assign w_count_next = w_count + CW'(w_push_eff) - CW'(w_pop);

    router_in_port_pkt_fifo #(
        .WIDTH ($bits(pkt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_asm),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Byte assembler: header first, then data MSB first; gaps hold position.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte_cnt <= 2'd0;
            r_src      <= 4'd0;
            r_dest     <= 4'd0;
            r_data_hi  <= 16'd0;
        end else begin
            r_byte_cnt <= w_cnt_next;
            if (w_take) begin
                case (r_byte_cnt)
                    2'd0:    {r_src, r_dest}  <= port_if.payload_in;
                    2'd1:    r_data_hi[15:8] <= port_if.payload_in;
                    2'd2:    r_data_hi[7:0]  <= port_if.payload_in;
                    default: ;
                endcase
            end
        end
    end

    // Upstream credit and sticky error flags, all computed from next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_free     <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_dest <= 1'b0;
        end else begin
            r_free <= (w_cnt_next == 2'd0) && (w_count_next < DEPTH_C);
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end
            if (w_last && w_dest_bad) begin
                r_err_dest <= 1'b1;
            end
        end
    end

    assign port_if.free_in   = r_free;
    assign port_if.pkt_valid = !w_empty;
    assign port_if.pkt_out   = w_empty ? '0 : w_head;
    assign port_if.req       = w_empty ? 4'b0000 : route_port(ROUTERID, w_head.dest);
    assign err_ovf           = r_err_ovf;
    assign err_dest          = r_err_dest;

endmodule

// File: tb/tb_router_in_port.sv
// Self-checking bench for router_in_port: directed scenarios followed by
// randomized packet traffic, all compared against a packet-level model.
module tb_router_in_port;
    import router_in_port_pkg::*;

    localparam int ROUTERID = 0;
    localparam int DEPTH    = 4;

    logic clock;
    logic reset;
    logic errOvf;
    logic errDest;

    router_in_port_if ifc ();

    router_in_port #(
        .ROUTERID (ROUTERID),
        .DEPTH    (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .port_if  (ifc),
        .err_ovf  (errOvf),
        .err_dest (errDest)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   nChecks = 0;
    int   nFails  = 0;

    // Reference model: queue of accepted packets plus upstream-side state.
    pkt_t mQ[$];
    pkt_t mAsm;
    bit   mBusy;
    int   mPhase;
    bit   mOvf;
    bit   mDest;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Destination to port, stated as node-group arithmetic.
    function automatic logic [3:0] expRoute(logic [3:0] d);
        if (d > 4'd5) return 4'b0000;
        if (int'(d) / 3 == ROUTERID) return 4'(1 << (int'(d) % 3));
        return 4'b1000;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkModel();
        pkt_t expPkt;
        logic [3:0] expReq;
        expPkt = '0;
        expReq = 4'b0000;
        if (mQ.size() > 0) begin
            expPkt = mQ[0];
            expReq = expRoute(mQ[0].dest);
        end
        checkOutput("pkt_valid", 32'(ifc.pkt_valid), 32'(mQ.size() > 0));
        checkOutput("pkt_out", ifc.pkt_out, expPkt);
        checkOutput("req", 32'(ifc.req), 32'(expReq));
        checkOutput("free_in", 32'(ifc.free_in), 32'(!mBusy && mQ.size() < DEPTH));
        checkOutput("err_ovf", 32'(errOvf), 32'(mOvf));
        checkOutput("err_dest", 32'(errDest), 32'(mDest));
    endtask

    // One clock of stimulus, then advance the model and compare.
    task automatic applyStimulus(input bit put, input logic [7:0] b, input bit g);
        bit wasFull;
        ifc.put_in     = put;
        ifc.payload_in = b;
        ifc.grant      = g;
        wasFull = (mQ.size() == DEPTH);
        tick();
        if (g && mQ.size() > 0) void'(mQ.pop_front());
        if (put) begin
            if (!mBusy) begin
                if (wasFull) begin
                    mOvf = 1'b1;
                end else begin
                    mBusy      = 1'b1;
                    mPhase     = 1;
                    mAsm.src   = b[7:4];
                    mAsm.dest  = b[3:0];
                end
            end else begin
                case (mPhase)
                    1: mAsm.data[23:16] = b;
                    2: mAsm.data[15:8]  = b;
                    default: begin
                        mAsm.data[7:0] = b;
                        mBusy = 1'b0;
                        if (mAsm.dest > 4'd5) mDest = 1'b1;
                        else mQ.push_back(mAsm);
                    end
                endcase
                mPhase++;
            end
        end
        ifc.put_in = 1'b0;
        ifc.grant  = 1'b0;
        checkModel();
    endtask

    function automatic bit pickGrant(int mode, bit last);
        if (mode == 1) return bit'($urandom_range(0, 1));
        return (mode == 2) && last;
    endfunction

    // grantMode: 0 never, 1 random each cycle, 2 only with the last byte.
    task automatic sendPacket(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int gapMin, input int gapMax, input int grantMode);
        logic [7:0] bytes [4];
        int gap;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, bytes[i], pickGrant(grantMode, i == 3));
            if (i < 3) begin
                gap = $urandom_range(gapMax, gapMin);
                for (int k = 0; k < gap; k++) applyStimulus(1'b0, 8'h00, pickGrant(grantMode, 1'b0));
            end
        end
    endtask

    task automatic drainAll();
        for (int i = 0; i < 2 * DEPTH + 2 && mQ.size() > 0; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain_empty", 32'(ifc.pkt_valid), 32'd0);
    endtask

    task automatic doReset(input int n);
        ifc.put_in = 1'b0;
        ifc.grant  = 1'b0;
        reset      = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput("rst_free", 32'(ifc.free_in), 32'd0);
            checkOutput("rst_valid", 32'(ifc.pkt_valid), 32'd0);
            checkOutput("rst_req", 32'(ifc.req), 32'd0);
            checkOutput("rst_pkt", ifc.pkt_out, 32'd0);
            checkOutput("rst_errs", {30'd0, errOvf, errDest}, 32'd0);
        end
        mQ.delete();
        mBusy  = 1'b0;
        mPhase = 0;
        mOvf   = 1'b0;
        mDest  = 1'b0;
        reset  = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("free_after_rst", 32'(ifc.free_in), 32'd1);
    endtask

    initial begin
        logic [7:0] r0;
        reset          = 1'b1;
        ifc.put_in     = 1'b0;
        ifc.payload_in = 8'h00;
        ifc.grant      = 1'b0;
        mAsm           = '0;
        doReset(2);

        $display("[TB] test 1: basic packet");
        sendPacket(8'h02, 8'hAB, 8'hCD, 8'hEF, 0, 0, 0);
        checkOutput("t1_pkt", ifc.pkt_out, 32'h02ABCDEF);
        checkOutput("t1_req", 32'(ifc.req), 32'b0100);
        applyStimulus(1'b0, 8'h00, 1'b1);

        $display("[TB] test 2: inter-router dest and pop");
        sendPacket(8'h14, 8'h01, 8'h02, 8'h03, 0, 0, 0);
        checkOutput("t2_req", 32'(ifc.req), 32'b1000);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t2_valid", 32'(ifc.pkt_valid), 32'd0);
        checkOutput("t2_req0", 32'(ifc.req), 32'd0);

        $display("[TB] test 3: fill and overflow");
        for (int p = 0; p < 3; p++) sendPacket(8'h01, 8'(p), 8'h11, 8'h22, 0, 0, 0);
        applyStimulus(1'b1, 8'h52, 1'b0);
        checkOutput("t3_free_byte0", 32'(ifc.free_in), 32'd0);
        applyStimulus(1'b1, 8'h66, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b1, 8'h88, 1'b0);
        checkOutput("t3_free_full", 32'(ifc.free_in), 32'd0);
        sendPacket(8'h03, 8'h99, 8'h99, 8'h99, 0, 0, 0);
        checkOutput("t3_ovf", 32'(errOvf), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_free_grant", 32'(ifc.free_in), 32'd1);
        drainAll();

        $display("[TB] test 4: gapped bytes");
        sendPacket(8'h02, 8'hAB, 8'hCD, 8'hEF, 2, 2, 0);
        checkOutput("t4_pkt", ifc.pkt_out, 32'h02ABCDEF);

        $display("[TB] test 5: push and pop on the same edge");
        sendPacket(8'h31, 8'h11, 8'h22, 8'h33, 0, 0, 2);
        checkOutput("t5_pkt", ifc.pkt_out, 32'h31112233);
        checkOutput("t5_valid", 32'(ifc.pkt_valid), 32'd1);

        $display("[TB] test 6: reset mid-packet and bad dest");
        applyStimulus(1'b1, 8'h05, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b0);
        doReset(2);
        sendPacket(8'h21, 8'h9A, 8'hBC, 8'hDE, 0, 0, 0);
        checkOutput("t6_pkt", ifc.pkt_out, 32'h219ABCDE);
        checkOutput("t6_req", 32'(ifc.req), 32'b0010);
        drainAll();
        sendPacket(8'h07, 8'h01, 8'h02, 8'h03, 0, 0, 0);
        checkOutput("t6_err_dest", 32'(errDest), 32'd1);
        checkOutput("t6_valid", 32'(ifc.pkt_valid), 32'd0);

        $display("[TB] random traffic");
        for (int p = 0; p < 40; p++) begin
            for (int w = 0; w < 30 && ifc.free_in !== 1'b1; w++)
                applyStimulus(1'b0, 8'h00, bit'($urandom_range(0, 1)));
            checkOutput("rand_free_wait", 32'(ifc.free_in), 32'd1);
            r0 = {4'($urandom_range(15, 0)), 4'($urandom_range(7, 0))};
            sendPacket(r0, 8'($urandom), 8'($urandom), 8'($urandom), 0, 2, 1);
        end
        drainAll();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
